// File: rtl/uart_pkg.sv
// uart_pkg: shared types and line levels for the UART transmit path.
//   tx_state_t  : transmitter frame state
//   IDLE_LEVEL  : line level between frames
//   START_LEVEL : start-bit level
//   STOP_LEVEL  : stop-bit level
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/uart_tx_ser_baud_tick.sv
// baud_tick: bit-period cycle counter for the UART transmitter.
// Counts 0..CLKS_PER_BIT-1 while en is high and wraps to 0; tick is high
// for the single cycle in which the counter sits at its terminal value.
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset (counter to 0)
//   clr  : synchronous clear, restarts the bit period
//   en   : count enable
//   tick : terminal-count strobe (combinational from the counter)
module baud_tick #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_ser.sv
// uart_tx_ser: byte-wide UART transmitter (8N1, optional even parity).
// Accepts a word on valid && ready, then sends start bit, DATA_W data bits
// LSB first, optional parity bit and one stop bit, each CLKS_PER_BIT cycles.
//   clk   : system clock, rising edge
//   rst   : synchronous active-high reset, aborts any frame in progress
//   data  : word to send, sampled only on accept
//   valid : producer offers data
//   ready : transmitter can accept a word this cycle (state is IDLE)
//   txd   : registered serial output, idle high
//   busy  : a frame is in progress
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit
// between the last data bit and the stop bit.
module uart_tx_ser
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned DATA_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data,
  input  logic              valid,
  output logic              ready,
  output logic              txd,
  output logic              busy
);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("uart_tx_ser: CLKS_PER_BIT must be >= 2");
  end

  localparam int unsigned BIT_W = $clog2(DATA_W + 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  tx_state_t         state;
  tx_state_t         state_nxt;
  logic [DATA_W-1:0] shreg;
  logic [BIT_W-1:0]  bit_idx;
  logic              txd_q;
  logic              txd_nxt;
  logic              accept;
  logic              tick;
  logic              last_bit;
`ifdef UART_TX_PARITY_EN
  logic              par_q;
`endif

  assign ready    = (state == IDLE);
  assign busy     = (state != IDLE);
  assign accept   = valid && ready;
  assign last_bit = (bit_idx == LAST_BIT);
  assign txd      = txd_q;

  // Cleared on accept so every bit period is aligned to the accept edge.
  baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .en  (busy),
    .tick(tick)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (accept) state_nxt = START;
      START: if (tick) state_nxt = DATA;
      DATA: begin
        if (tick && last_bit) begin
`ifdef UART_TX_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (tick) state_nxt = STOP;
`endif
      STOP:  if (tick) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: txd is registered, so this computes the level the line
  // takes from the next edge. During DATA the bit after the current one is
  // shreg[1], because the shift happens on the same edge.
  always_comb begin
    txd_nxt = txd_q;
    if (accept) begin
      txd_nxt = START_LEVEL;
    end else if (tick) begin
      unique case (state)
        START: txd_nxt = shreg[0];
        DATA: begin
          if (last_bit) begin
`ifdef UART_TX_PARITY_EN
            txd_nxt = par_q;
`else
            txd_nxt = STOP_LEVEL;
`endif
          end else begin
            txd_nxt = shreg[1];
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: txd_nxt = STOP_LEVEL;
`endif
        STOP:    txd_nxt = IDLE_LEVEL;
        default: txd_nxt = IDLE_LEVEL;
      endcase
    end
  end

  // Datapath registers: shifter, bit index, line driver and parity latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg   <= '0;
      bit_idx <= '0;
      txd_q   <= IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      txd_q <= txd_nxt;
      if (accept) begin
        shreg   <= data;
        bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
        par_q   <= ^data;
`endif
      end else if ((state == DATA) && tick) begin
        shreg   <= shreg >> 1;
        bit_idx <= last_bit ? '0 : bit_idx + BIT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_ser.sv
// tb_uart_tx_ser: directed self-checking bench for uart_tx_ser with
// CLKS_PER_BIT=4, DATA_W=8. Honours UART_TX_PARITY_EN the same way the RTL does.
module tb_uart_tx_ser;

  localparam int CPB = 4;
  localparam int DW  = 8;
`ifdef UART_TX_PARITY_EN
  localparam int NB  = DW + 3;
`else
  localparam int NB  = DW + 2;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] data;
  logic          valid;
  logic          ready;
  logic          txd;
  logic          busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] d;
    logic       p;
  } vec_t;

  vec_t vecs[7];
  int   a5_seq[NB];

  uart_tx_ser #(
    .CLKS_PER_BIT(CPB),
    .DATA_W      (DW)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .data (data),
    .valid(valid),
    .ready(ready),
    .txd  (txd),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " txd"}, txd, 1'b1);
    chk({tag, " ready"}, ready, 1'b1);
    chk({tag, " busy"}, busy, 1'b0);
  endtask

  // Waits (bounded) for ready, presents d, and returns #1 after the accept edge.
  task automatic send(input logic [7:0] d, input logic hold);
    int n;
    @(negedge clk);
    n = 0;
    while (!ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("ready before accept %02h", d), ready, 1'b1);
    data  = d;
    valid = 1'b1;
    @(posedge clk);
    #1;
    valid = hold;
  endtask

  // Called #1 after the accept edge; checks every cycle of the frame and
  // returns #1 after the edge that ends the stop bit.
  task automatic check_frame(input logic [7:0] d, input logic p, input int disturb);
    int  b;
    logic e;
    for (int c = 0; c < NB * CPB; c++) begin
      b = c / CPB;
      if (b == 0) e = 1'b0;
      else if (b <= DW) e = d[b-1];
`ifdef UART_TX_PARITY_EN
      else if (b == DW + 1) e = p;
`endif
      else e = 1'b1;
      chk($sformatf("txd %02h c%0d", d, c), txd, e);
      chk($sformatf("ready %02h c%0d", d, c), ready, 1'b0);
      chk($sformatf("busy %02h c%0d", d, c), busy, 1'b1);
      if (disturb >= 0 && c == disturb) begin
        data  = ~d;
        valid = 1'b1;
      end else if (disturb >= 0 && c == disturb + 1) begin
        valid = 1'b0;
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{d: 8'h00, p: 1'b0};
    vecs[1] = '{d: 8'hFF, p: 1'b0};
    vecs[2] = '{d: 8'h3C, p: 1'b0};
    vecs[3] = '{d: 8'h07, p: 1'b1};
    vecs[4] = '{d: 8'h03, p: 1'b0};
    vecs[5] = '{d: 8'h81, p: 1'b0};
    vecs[6] = '{d: 8'h80, p: 1'b1};
`ifdef UART_TX_PARITY_EN
    a5_seq = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
`else
    a5_seq = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
`endif

    rst   = 1'b1;
    valid = 1'b0;
    data  = '0;

    // Reset, then 20 idle cycles with no valid.
    repeat (3) @(posedge clk);
    #1;
    chk_idle("reset");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk_idle($sformatf("idle c%0d", i));
    end

    // valid held through reset: no accept until the first edge with rst=0.
    @(negedge clk);
    rst   = 1'b1;
    valid = 1'b1;
    data  = 8'h55;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk_idle("valid in reset");
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    valid = 1'b0;
    check_frame(8'h55, 1'b0, -1);
    chk_idle("after 55");

    // 8'hA5 against a literal bit sequence.
    send(8'hA5, 1'b0);
    for (int c = 0; c < NB * CPB; c++) begin
      chk($sformatf("a5 txd c%0d", c), txd, a5_seq[c / CPB] != 0);
      chk($sformatf("a5 ready c%0d", c), ready, 1'b0);
      @(posedge clk);
      #1;
    end
    chk_idle("after a5");

    // Table of single frames.
    for (int i = 0; i < 7; i++) begin
      send(vecs[i].d, 1'b0);
      check_frame(vecs[i].d, vecs[i].p, -1);
      chk_idle($sformatf("after vec%0d", i));
    end

    // Back-to-back with valid held: exactly one idle-high cycle between frames.
    send(8'h00, 1'b1);
    data = 8'hFF;
    check_frame(8'h00, 1'b0, -1);
    chk_idle("gap cycle");
    @(posedge clk);
    #1;
    valid = 1'b0;
    check_frame(8'hFF, 1'b0, -1);
    chk_idle("after b2b");

    // Reset at cycle 15 of a frame aborts it.
    send(8'h3C, 1'b0);
    repeat (14) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_idle("abort edge");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk($sformatf("post abort txd c%0d", i), txd, 1'b1);
      chk($sformatf("post abort busy c%0d", i), busy, 1'b0);
    end

    // data change and valid pulse while busy are ignored.
    send(8'h81, 1'b0);
    check_frame(8'h81, 1'b0, 5);
    chk_idle("after disturb");
    repeat (4) @(negedge clk);
    chk_idle("disturb no accept");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
